// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// LED pattern engine for board bring-up. A free-running prescaler produces a
// one-clock `tick` every 2^PRESCALE_W clocks; each tick advances the selected
// pattern on the LED bank.
//
//   mode 0 : binary down-counter (classic blinky)
//   mode 1 : binary up-counter
//   mode 2 : bouncing one-hot scanner, end bits shown once per pass
//   mode 3 : "breathe" - PWM duty ramps up and down, all LEDs share the duty
//
// `mode` is only looked at on tick edges. A new mode spends its first tick
// loading its start state, so a mode switch never shows a half-stepped value.
//
// Parameters
//   N_LED      : LED bank width (>= 1)
//   PRESCALE_W : prescaler width, tick period is 2^PRESCALE_W clocks
//   PWM_W      : PWM counter / duty width for breathe mode (>= 2)
//
// Ports
//   clk    in   fabric clock, rising edge
//   resetn in   asynchronous active-low reset (deassert synchronously upstream)
//   mode   in   pattern select, 2 bits
//   pause  in   freezes prescaler and pattern while high (PWM keeps running)
//   led    out  LED drive, active-high, registered
//   tick   out  one-clock pulse marking a pattern step, registered
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int N_LED      = 4,
  parameter int PRESCALE_W = 20,
  parameter int PWM_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  typedef enum logic [1:0] {
    MODE_DOWN    = 2'd0,
    MODE_UP      = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Direction is shared by scanner and breathe; both reload it on entry.
  // "Up" is encoded as 0 so the reset value is a valid start direction.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [N_LED-1:0] SCAN_INIT = N_LED'(1);

  // Registered state
  logic [PRESCALE_W-1:0] pre;
  logic [N_LED-1:0]      cnt;
  logic [N_LED-1:0]      scan;
  logic                  dir;
  logic [PWM_W-1:0]      duty;
  logic [PWM_W-1:0]      pwm_cnt;
  mode_e                 mode_q;

  // Next-state values
  logic                  step;
  mode_e                 mode_in;
  mode_e                 mode_n;
  logic [N_LED-1:0]      cnt_n;
  logic [N_LED-1:0]      scan_n;
  logic                  dir_n;
  logic [PWM_W-1:0]      duty_n;
  logic [N_LED-1:0]      led_n;

  always_comb begin
    // A tick that coincides with pause is dropped, so a pending mode
    // change waits for the next unpaused tick.
    step    = tick & ~pause;
    mode_in = mode_e'(mode);
    mode_n  = mode_q;
    cnt_n   = cnt;
    scan_n  = scan;
    dir_n   = dir;
    duty_n  = duty;

    if (step) begin
      if (mode_in != mode_q) begin
        // Entering a new mode: load its start state, do not step.
        mode_n = mode_in;
        case (mode_in)
          MODE_DOWN, MODE_UP: cnt_n = '0;
          MODE_SCAN: begin
            scan_n = SCAN_INIT;
            dir_n  = DIR_UP;
          end
          default: begin
            duty_n = '0;
            dir_n  = DIR_UP;
          end
        endcase
      end else begin
        case (mode_q)
          MODE_DOWN: cnt_n = cnt - 1'b1;
          MODE_UP:   cnt_n = cnt + 1'b1;
          MODE_SCAN: begin
            if (N_LED == 1) begin
              scan_n = scan;
            end else if (dir == DIR_UP) begin
              scan_n = scan << 1;
              // Turn around in the same step that lands on the end bit,
              // so the end bit is shown for one tick only.
              if (scan_n[N_LED-1]) dir_n = DIR_DOWN;
            end else begin
              scan_n = scan >> 1;
              if (scan_n[0]) dir_n = DIR_UP;
            end
          end
          default: begin
            if (dir == DIR_UP) begin
              duty_n = duty + 1'b1;
              if (&duty_n) dir_n = DIR_DOWN;
            end else begin
              duty_n = duty - 1'b1;
              if (duty_n == '0) dir_n = DIR_UP;
            end
          end
        endcase
      end
    end

    // Counter/scanner LEDs show the freshly stepped value one clock after
    // tick. Breathe LEDs are a registered compare of the current PWM
    // counter and duty, i.e. one stage behind them.
    case (mode_n)
      MODE_SCAN:    led_n = scan_n;
      MODE_BREATHE: led_n = {N_LED{pwm_cnt < duty}};
      default:      led_n = cnt_n;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre     <= '0;
      tick    <= 1'b0;
      cnt     <= '0;
      scan    <= '0;
      dir     <= DIR_UP;
      duty    <= '0;
      pwm_cnt <= '0;
      mode_q  <= MODE_DOWN;
      led     <= '0;
    end else begin
      if (!pause) pre <= pre + 1'b1;
      tick    <= (&pre) & ~pause;
      // PWM keeps running through pause so a paused breathe stays lit.
      pwm_cnt <= pwm_cnt + 1'b1;
      mode_q  <= mode_n;
      cnt     <= cnt_n;
      scan    <= scan_n;
      dir     <= dir_n;
      duty    <= duty_n;
      led     <= led_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Bench for led_pattern_gen with PRESCALE_W = 4, N_LED = 4, PWM_W = 4.
// A behavioural model tracks each pattern as a position in its cyclic
// sequence (counter value, bounce index, triangle-wave index) and is compared
// with the DUT on every falling edge. Directed sections pin the model with
// hand-computed LED values, tick spacings and PWM on-times.
// Inputs change only on falling edges; the model samples them on rising edges.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int NL       = 4;
  localparam int PW       = 4;
  localparam int MW       = 4;
  localparam int CLK_HALF = 5;
  localparam int TICK_T   = 1 << PW;        // clocks per tick
  localparam int CNT_M    = 1 << NL;        // counter modulus
  localparam int DMAX     = (1 << MW) - 1;  // largest duty
  localparam int SCAN_P   = 2 * NL - 2;     // scanner bounce period in ticks
  localparam int BR_P     = 2 * DMAX;       // breathe triangle period in ticks

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    mode;
  logic          pause;
  logic [NL-1:0] led;
  logic          tick;

  always #CLK_HALF clk = ~clk;

  led_pattern_gen #(
    .N_LED      (NL),
    .PRESCALE_W (PW),
    .PWM_W      (MW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .mode   (mode),
    .pause  (pause),
    .led    (led),
    .tick   (tick)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  time last_tick_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    int mode;  // active pattern
    int cnt;   // counter value for modes 0/1
    int si;    // index into scanner bounce sequence
    int bi;    // index into breathe triangle sequence
  } mstate_t;

  mstate_t       m_st  = '0;
  int            m_pre = 0;
  int            m_pwm = 0;
  bit            m_tick = 1'b0;
  logic [NL-1:0] m_led = '0;

  // Scanner position for bounce index i: 0,1,..,NL-1,NL-2,..,1
  function automatic int scan_pos(input int i);
    return (i < NL) ? i : (2 * NL - 2 - i);
  endfunction

  // Duty for triangle index i: 0,1,..,DMAX,DMAX-1,..,1
  function automatic int duty_of(input int i);
    return (i <= DMAX) ? i : (2 * DMAX - i);
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input int md, input bit stepping);
    mstate_t n;
    n = s;
    if (stepping) begin
      if (md != s.mode) begin
        n.mode = md;
        if (md <= 1)      n.cnt = 0;
        else if (md == 2) n.si  = 0;
        else              n.bi  = 0;
      end else begin
        case (s.mode)
          0:       n.cnt = (s.cnt + CNT_M - 1) % CNT_M;
          1:       n.cnt = (s.cnt + 1) % CNT_M;
          2:       n.si  = (s.si + 1) % SCAN_P;
          default: n.bi  = (s.bi + 1) % BR_P;
        endcase
      end
    end
    return n;
  endfunction

  function automatic logic [NL-1:0] model_led(input mstate_t nx, input mstate_t cur, input int pwm);
    logic [NL-1:0] v;
    if (nx.mode == 3)      v = (pwm < duty_of(cur.bi)) ? '1 : '0;
    else if (nx.mode == 2) v = NL'(1 << scan_pos(nx.si));
    else                   v = NL'(nx.cnt);
    return v;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_st   <= '0;
      m_pre  <= 0;
      m_pwm  <= 0;
      m_tick <= 1'b0;
      m_led  <= '0;
    end else begin
      m_st   <= model_next(m_st, int'(mode), m_tick && !pause);
      m_led  <= model_led(model_next(m_st, int'(mode), m_tick && !pause), m_st, m_pwm);
      m_tick <= (m_pre == TICK_T - 1) && !pause;
      m_pre  <= pause ? m_pre : (m_pre + 1) % TICK_T;
      m_pwm  <= (m_pwm + 1) % (1 << MW);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("tick_vs_model", 32'(tick), 32'(m_tick));
    check("led_vs_model", 32'(led), 32'(m_led));
  end

  // ---------------------------------------------------------------- drivers
  // Wait for the next tick-high cycle and check its spacing (in clocks)
  // from the previous tick or from the reference point set by the caller.
  task automatic wait_tick(input int exp_gap, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual no tick in 100 clocks required tick after %0d", name, exp_gap);
    end else begin
      check(name, 32'(($time - last_tick_t) / (2 * CLK_HALF)), 32'(exp_gap));
    end
    last_tick_t = $time;
  endtask

  task automatic check_led_next(input logic [NL-1:0] exp, input string name);
    @(negedge clk);
    check(name, 32'(led), 32'(exp));
  endtask

  // Count LED-on samples over one full PWM period.
  task automatic pwm_window(output int highs);
    highs = 0;
    for (int i = 0; i < TICK_T; i++) begin
      @(negedge clk);
      if (tick === 1'b1) last_tick_t = $time;
      if (led == '1) highs++;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [NL-1:0] exp_down [17] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
                                   4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF};
  logic [NL-1:0] exp_up   [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                   4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
  logic [NL-1:0] exp_scan [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    int highs;
    resetn = 1'b0;
    mode   = 2'd0;
    pause  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);

    // Mode 0 from reset, with a 40-clock pause after LED shows B.
    resetn = 1'b1;
    last_tick_t = $time;
    for (int i = 0; i < 17; i++) begin
      // Pause is released with pre held at 5, so that tick arrives 11 clocks later.
      wait_tick((i == 5) ? 11 : TICK_T, "m0_tick_gap");
      check_led_next(exp_down[i], "m0_led");
      if (i == 4) begin
        repeat (4) @(negedge clk);
        pause = 1'b1;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          check("pause_tick", 32'(tick), 32'h0);
          check("pause_led", 32'(led), 32'hB);
        end
        pause = 1'b0;
        last_tick_t = $time;
      end
    end

    // Mode 1 held through reset: first tick only latches the mode.
    resetn = 1'b0;
    mode   = 2'd1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last_tick_t = $time;
    wait_tick(TICK_T, "m1_first_tick_gap");
    check_led_next(4'h0, "m1_latch_led");
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        // Pause for exactly the clock where pre is all-ones: that tick is
        // suppressed and arrives one clock late.
        repeat (14) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        check("pause_wrap_tick", 32'(tick), 32'h0);
        pause = 1'b0;
      end
      wait_tick((i == 3) ? TICK_T + 1 : TICK_T, "m1_tick_gap");
      check_led_next(exp_up[i], "m1_led");
    end

    // Scanner, with a 2->1->2 toggle between two ticks that must not reinit.
    mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      wait_tick(TICK_T, "m2_tick_gap");
      check_led_next(exp_scan[i], "m2_led");
      if (i == 2) begin
        mode = 2'd1;
        repeat (3) @(negedge clk);
        mode = 2'd2;
      end
    end

    // Breathe: switch, then 5 more ticks give duty 5.
    mode = 2'd3;
    wait_tick(TICK_T, "m3_switch_gap");
    repeat (5) wait_tick(TICK_T, "m3_tick_gap");
    @(negedge clk);
    pwm_window(highs);
    check("m3_duty5_on", 32'(highs), 32'd5);
    // The window covered one more tick (duty 6); nine more reach 15.
    repeat (9) wait_tick(TICK_T, "m3_tick_gap");
    @(negedge clk);
    pwm_window(highs);
    check("m3_duty15_on", 32'(highs), 32'd15);
    pwm_window(highs);
    check("m3_duty14_on", 32'(highs), 32'd14);

    // Asynchronous reset mid-scanner, dropped between clock edges during a tick.
    mode = 2'd2;
    wait_tick(TICK_T, "m2b_switch_gap");
    check_led_next(4'b0001, "m2b_led");
    wait_tick(TICK_T, "m2b_tick_gap");
    #2 resetn = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_tick", 32'(tick), 32'h0);
    mode = 2'd0;
    @(negedge clk);
    resetn = 1'b1;
    last_tick_t = $time;
    wait_tick(TICK_T, "post_reset_tick_gap");
    check_led_next(4'hF, "post_reset_led");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
